i2lbs_scan_controller: RTL and testbench

//  Next-generation window sequencer for the I2LBS face-detection path, on the single clk_fpga domain.

---
 rtl/i2lbs_pkg.sv | 25 ++
 rtl/i2lbs_window_counter.sv | 45 ++++
 rtl/i2lbs_scan_controller.sv | 154 +++++++++++++++
 tb/tb_i2lbs_scan_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/i2lbs_pkg.sv
// Shared types and helpers for the I2LBS scan controller.
package i2lbs_pkg;

  localparam int COORD_W   = 12;
  localparam int MAX_LANES = 16;

  typedef enum logic [1:0] {
    IDLE,
    INSPECT,
    EMIT,
    REQUEST
  } state_t;

  function automatic logic [MAX_LANES-1:0] lane_mask(
    input int n
  );
    logic [MAX_LANES-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < n) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/i2lbs_window_counter.sv
// Window x/y scan position, wrapping at the last full window of a frame.
module i2lbs_window_counter
  import i2lbs_pkg::*;
#(
  parameter int W       = COORD_W,
  parameter int FRAME_W = 10,
  parameter int FRAME_H = 10,
  parameter int WIN_W   = 3,
  parameter int WIN_H   = 3
) (
  input  logic         clk_fpga,
  input  logic         reset_fpga,
  input  logic         advance,
  output logic [W-1:0] x,
  output logic [W-1:0] y,
  output logic         frame_done
);

  localparam logic [W-1:0] X_LAST = W'(FRAME_W - WIN_W - 1);
  localparam logic [W-1:0] Y_LAST = W'(FRAME_H - WIN_H - 1);

  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      x          <= '0;
      y          <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (advance) begin
        if (x == X_LAST) begin
          x <= '0;
          if (y == Y_LAST) begin
            y          <= '0;
            frame_done <= 1'b1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/i2lbs_scan_controller.sv
// I2LBS window sequencer: lane dispatch, pass collection, candidate emit.
// Optional INSPECT watchdog enabled by defining I2LBS_WATCHDOG_EN.
module i2lbs_scan_controller
  import i2lbs_pkg::*;
#(
  parameter int NUM_LANES           = 4,
  parameter int DATA_WIDTH_12       = COORD_W,
  parameter int INTEGRAL_WIDTH      = 3,
  parameter int INTEGRAL_HEIGHT     = 3,
  parameter int FRAME_RESIZE_WIDTH  = 10,
  parameter int FRAME_RESIZE_HEIGHT = 10,
  parameter int TIMEOUT_WIDTH       = 10
) (
  input  logic                     clk_fpga,
  input  logic                     reset_fpga,
  input  logic                     i_reach,
  input  logic                     i_integral_ready,
  input  logic                     i_pixel_recieve,
  input  logic [NUM_LANES-1:0]     i_lane_done,
  input  logic [NUM_LANES-1:0]     i_lane_pass,
  input  logic                     i_candidate_ready,
  output logic [NUM_LANES-1:0]     o_lane_start,
  output logic                     o_database_request,
  output logic                     o_pixel_request,
  output logic                     o_candidate_valid,
  output logic [DATA_WIDTH_12-1:0] o_candidate_x,
  output logic [DATA_WIDTH_12-1:0] o_candidate_y,
  output logic [NUM_LANES-1:0]     o_candidate_mask,
  output logic                     o_frame_done,
  output logic                     o_timeout,
  output logic                     o_busy
);

  if (NUM_LANES < 1 || NUM_LANES > MAX_LANES ||
      TIMEOUT_WIDTH < 2) begin : g_bad_cfg
    $error("i2lbs_scan_controller: bad parameters");
  end

  localparam logic [MAX_LANES-1:0] ALL16 = lane_mask(NUM_LANES);
  localparam logic [NUM_LANES-1:0] ALL_LANES = ALL16[NUM_LANES-1:0];

  state_t                     state;
  logic [NUM_LANES-1:0]       done_r;
  logic [NUM_LANES-1:0]       pass_r;
  logic [NUM_LANES-1:0]       done_nx;
  logic [NUM_LANES-1:0]       pass_nx;
  logic                       wd_hit;
  logic                       exit_inspect;
  logic                       advance;
  logic [DATA_WIDTH_12-1:0]   win_x;
  logic [DATA_WIDTH_12-1:0]   win_y;

  // A pass only counts when its lane reports done in the same cycle.
  assign done_nx      = done_r | i_lane_done;
  assign pass_nx      = pass_r | (i_lane_pass & i_lane_done);
  assign exit_inspect = (&done_nx) | wd_hit;
  assign advance      = (state == REQUEST) & i_pixel_recieve;
  assign o_busy       = (state != IDLE);

`ifdef I2LBS_WATCHDOG_EN
  logic [TIMEOUT_WIDTH-1:0] wd_cnt;

  assign wd_hit = (state == INSPECT) && (wd_cnt == '1);

  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      wd_cnt    <= TIMEOUT_WIDTH'(1);
      o_timeout <= 1'b0;
    end else begin
      o_timeout <= wd_hit;
      if (state == INSPECT) wd_cnt <= wd_cnt + 1'b1;
      else                  wd_cnt <= TIMEOUT_WIDTH'(1);
    end
  end
`else
  assign wd_hit    = 1'b0;
  assign o_timeout = 1'b0;
`endif

  i2lbs_window_counter #(
    .W       (DATA_WIDTH_12),
    .FRAME_W (FRAME_RESIZE_WIDTH),
    .FRAME_H (FRAME_RESIZE_HEIGHT),
    .WIN_W   (INTEGRAL_WIDTH),
    .WIN_H   (INTEGRAL_HEIGHT)
  ) u_win (
    .clk_fpga   (clk_fpga),
    .reset_fpga (reset_fpga),
    .advance    (advance),
    .x          (win_x),
    .y          (win_y),
    .frame_done (o_frame_done)
  );

  always_ff @(posedge clk_fpga or posedge reset_fpga) begin
    if (reset_fpga) begin
      state              <= IDLE;
      done_r             <= '0;
      pass_r             <= '0;
      o_lane_start       <= '0;
      o_database_request <= 1'b0;
      o_pixel_request    <= 1'b0;
      o_candidate_valid  <= 1'b0;
      o_candidate_x      <= '0;
      o_candidate_y      <= '0;
      o_candidate_mask   <= '0;
    end else begin
      o_lane_start <= '0;
      unique case (state)
        IDLE: begin
          if (i_reach && i_integral_ready) begin
            state              <= INSPECT;
            done_r             <= '0;
            pass_r             <= '0;
            o_lane_start       <= ALL_LANES;
            o_database_request <= 1'b1;
          end
        end
        INSPECT: begin
          done_r <= done_nx;
          pass_r <= pass_nx;
          if (exit_inspect) begin
            o_database_request <= 1'b0;
            if (|pass_nx) begin
              state             <= EMIT;
              o_candidate_valid <= 1'b1;
              o_candidate_x     <= win_x;
              o_candidate_y     <= win_y;
              o_candidate_mask  <= pass_nx;
            end else begin
              state           <= REQUEST;
              o_pixel_request <= 1'b1;
            end
          end
        end
        EMIT: begin
          if (i_candidate_ready) begin
            state             <= REQUEST;
            o_candidate_valid <= 1'b0;
            o_pixel_request   <= 1'b1;
          end
        end
        REQUEST: begin
          if (i_pixel_recieve) begin
            state           <= IDLE;
            o_pixel_request <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2lbs_scan_controller.sv
// Directed plus randomized bench for i2lbs_scan_controller.
module tb_i2lbs_scan_controller;

  localparam int NL = 4;
  localparam int W  = 12;
  localparam int XN = 7;
  localparam int YN = 7;

  logic          clk_fpga = 1'b0;
  logic          reset_fpga = 1'b1;
  logic          i_reach = 1'b0;
  logic          i_integral_ready = 1'b0;
  logic          i_pixel_recieve = 1'b0;
  logic [NL-1:0] i_lane_done = '0;
  logic [NL-1:0] i_lane_pass = '0;
  logic          i_candidate_ready = 1'b0;
  logic [NL-1:0] o_lane_start;
  logic          o_database_request;
  logic          o_pixel_request;
  logic          o_candidate_valid;
  logic [W-1:0]  o_candidate_x;
  logic [W-1:0]  o_candidate_y;
  logic [NL-1:0] o_candidate_mask;
  logic          o_frame_done;
  logic          o_timeout;
  logic          o_busy;

  int tests = 0;
  int fails = 0;
  int acks  = 0;
  int dcs [NL];

  always #5 clk_fpga = ~clk_fpga;

  i2lbs_scan_controller #(
    .NUM_LANES           (NL),
    .DATA_WIDTH_12       (W),
    .INTEGRAL_WIDTH      (3),
    .INTEGRAL_HEIGHT     (3),
    .FRAME_RESIZE_WIDTH  (10),
    .FRAME_RESIZE_HEIGHT (10),
    .TIMEOUT_WIDTH       (4)
  ) dut (
    .clk_fpga           (clk_fpga),
    .reset_fpga         (reset_fpga),
    .i_reach            (i_reach),
    .i_integral_ready   (i_integral_ready),
    .i_pixel_recieve    (i_pixel_recieve),
    .i_lane_done        (i_lane_done),
    .i_lane_pass        (i_lane_pass),
    .i_candidate_ready  (i_candidate_ready),
    .o_lane_start       (o_lane_start),
    .o_database_request (o_database_request),
    .o_pixel_request    (o_pixel_request),
    .o_candidate_valid  (o_candidate_valid),
    .o_candidate_x      (o_candidate_x),
    .o_candidate_y      (o_candidate_y),
    .o_candidate_mask   (o_candidate_mask),
    .o_frame_done       (o_frame_done),
    .o_timeout          (o_timeout),
    .o_busy             (o_busy)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {o_lane_start, o_database_request,
              o_pixel_request, o_candidate_valid,
              o_candidate_x, o_candidate_y,
              o_candidate_mask, o_frame_done,
              o_timeout, o_busy}, 64'd0);
  endtask

  // One window: dc = INSPECT cycle (1-based) each lane finishes,
  // pv = pass bits, rdly = ready-low cycles, adly = ack delay.
  task automatic run_window(input int dc [NL],
                            input logic [NL-1:0] pv,
                            input int rdly,
                            input int adly);
    int maxc;
    logic [NL-1:0] d;
    logic [W-1:0] ex;
    logic [W-1:0] ey;
    ex = W'(acks % XN);
    ey = W'((acks / XN) % YN);
    maxc = 1;
    for (int i = 0; i < NL; i++)
      if (dc[i] > maxc) maxc = dc[i];
    i_reach = 1'b1;
    i_integral_ready = 1'b1;
    i_candidate_ready = (rdly == 0);
    @(negedge clk_fpga);
    i_reach = 1'b0;
    i_integral_ready = 1'($urandom_range(0, 1));
    chk("lane_start", o_lane_start, 4'hF);
    chk("db_req", o_database_request, 1);
    chk("busy", o_busy, 1);
    for (int c = 1; c <= maxc; c++) begin
      if (c == 2) chk("start_once", o_lane_start, 0);
      for (int i = 0; i < NL; i++) d[i] = (dc[i] == c);
      i_lane_done = d;
      i_lane_pass = (pv & d) | (NL'($urandom) & ~d);
      @(negedge clk_fpga);
    end
    i_lane_done = '0;
    i_lane_pass = '0;
    chk("db_req_drop", o_database_request, 0);
    if (pv != '0) begin
      chk("valid", o_candidate_valid, 1);
      chk("cand_x", o_candidate_x, ex);
      chk("cand_y", o_candidate_y, ey);
      chk("cand_mask", o_candidate_mask, pv);
      for (int k = 0; k < rdly; k++) begin
        @(negedge clk_fpga);
        chk("hold_valid", o_candidate_valid, 1);
        chk("hold_x", o_candidate_x, ex);
        chk("hold_y", o_candidate_y, ey);
        chk("hold_mask", o_candidate_mask, pv);
        chk("no_pixreq", o_pixel_request, 0);
      end
      i_candidate_ready = 1'b1;
      @(negedge clk_fpga);
      i_candidate_ready = 1'b0;
      chk("valid_drop", o_candidate_valid, 0);
      chk("pixreq_emit", o_pixel_request, 1);
    end else begin
      chk("fail_no_valid", o_candidate_valid, 0);
      chk("pixreq_fail", o_pixel_request, 1);
    end
    for (int k = 0; k < adly; k++) begin
      @(negedge clk_fpga);
      chk("pixreq_hold", o_pixel_request, 1);
    end
    i_pixel_recieve = 1'b1;
    @(negedge clk_fpga);
    i_pixel_recieve = 1'b0;
    acks++;
    chk("pixreq_drop", o_pixel_request, 0);
    chk("idle", o_busy, 0);
    chk("frame_done", o_frame_done, (acks % (XN * YN)) == 0);
    // stray ack and lane activity in IDLE must be ignored
    i_pixel_recieve = 1'($urandom_range(0, 1));
    i_lane_done = NL'($urandom);
    i_lane_pass = NL'($urandom);
    @(negedge clk_fpga);
    i_pixel_recieve = 1'b0;
    i_lane_done = '0;
    i_lane_pass = '0;
    chk("fd_single", o_frame_done, 0);
    chk("idle_stray", o_busy, 0);
  endtask

  initial begin
    int tcnt;
    logic [NL-1:0] pv;
    repeat (3) @(negedge clk_fpga);
    chk_all_zero("reset_outputs");
    reset_fpga = 1'b0;
    @(negedge clk_fpga);
    chk_all_zero("post_reset");

    dcs = '{2, 3, 5, 5};
    run_window(dcs, 4'b0101, 0, 0);
    dcs = '{1, 4, 2, 3};
    run_window(dcs, 4'b1010, 6, 2);
    dcs = '{3, 1, 2, 2};
    run_window(dcs, 4'b0000, 2, 1);

    while (acks < 52) begin
      for (int i = 0; i < NL; i++) dcs[i] = $urandom_range(1, 6);
      pv = NL'($urandom_range(1, 15));
      if (acks % 5 == 3) pv = '0;
      run_window(dcs, pv, $urandom_range(0, 3),
                 $urandom_range(0, 2));
    end

    // lane 2 never finishes
    i_reach = 1'b1;
    i_integral_ready = 1'b1;
    @(negedge clk_fpga);
    i_reach = 1'b0;
    i_integral_ready = 1'b0;
    i_lane_done = 4'b1011;
    i_lane_pass = 4'b0100;
    @(negedge clk_fpga);
    i_lane_done = '0;
    i_lane_pass = '0;
    tcnt = 0;
    for (int k = 0; k < 20; k++) begin
      if (o_timeout === 1'b1) tcnt++;
`ifndef I2LBS_WATCHDOG_EN
      chk("stuck_inspect", o_database_request, 1);
`endif
      chk("wd_no_valid", o_candidate_valid, 0);
      @(negedge clk_fpga);
    end
`ifdef I2LBS_WATCHDOG_EN
    chk("wd_pulses", tcnt, 1);
    chk("wd_pixreq", o_pixel_request, 1);
`else
    chk("no_timeout", tcnt, 0);
    chk("stuck_busy", o_busy, 1);
`endif

    #2 reset_fpga = 1'b1;
    #1 chk_all_zero("async_reset");
    @(negedge clk_fpga);
    reset_fpga = 1'b0;
    acks = 0;
    @(negedge clk_fpga);
    dcs = '{1, 1, 1, 1};
    run_window(dcs, 4'b1000, 1, 0);
    dcs = '{2, 1, 1, 3};
    run_window(dcs, 4'b0011, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
